// File: rtl/dll_ack_nak_gen.sv
// -----------------------------------------------------------------------------
// dll_ack_nak_gen
//
// Receive-side Ack/Nak generator for a PCIe-style data link layer.
// Each received TLP (tlp_done_i pulse) is classified against NEXT_RCV_SEQ:
//   * bad LCRC            -> discard, schedule a Nak (once per Nak episode)
//   * good, seq == NRS    -> commit to the transaction layer, NRS++
//   * good, duplicate     -> discard, schedule an Ack right away
//   * good, ahead of NRS  -> discard, schedule a Nak (once per Nak episode)
// Committed TLPs are acknowledged either when ACK_COALESCE of them have
// accumulated or when the oldest un-acked commit has waited ACK_TIMER_MAX
// cycles. A small FSM (IDLE / ACK_REQ / NAK_REQ) presents one Ack or Nak DLLP
// request at a time and holds it stable until the transmit path grants it.
//
// Parameters
//   SEQ_WIDTH      sequence-number width (arithmetic is mod 2**SEQ_WIDTH)
//   ACK_TIMER_MAX  cycles from first un-acked commit to a forced Ack
//   ACK_COALESCE   un-acked commits that trigger an Ack immediately
//
// Ports
//   sclk             in   system clock, rising edge
//   srst_n           in   asynchronous active-low reset
//   link_active_i    in   link up; low clears all state synchronously
//   tlp_done_i       in   one-cycle pulse at end of a received TLP
//   tlp_seq_i        in   sequence number of that TLP
//   tlp_crc_ok_i     in   LCRC check result of that TLP
//   tlp_commit_o     out  one-cycle pulse, TLP accepted (cycle after done)
//   tlp_discard_o    out  one-cycle pulse, TLP dropped (cycle after done)
//   dllp_req_o       out  Ack/Nak DLLP request
//   dllp_type_o      out  0 = Ack, 1 = Nak
//   dllp_seq_o       out  AckNak_Seq_Num carried by the DLLP
//   dllp_gnt_i       in   transmit path accepted the DLLP this cycle
//   next_rcv_seq_o   out  current NEXT_RCV_SEQ
//   nak_scheduled_o  out  a Nak episode is open (until in-sequence good TLP)
// -----------------------------------------------------------------------------
module dll_ack_nak_gen #(
    parameter int SEQ_WIDTH     = 12,
    parameter int ACK_TIMER_MAX = 64,
    parameter int ACK_COALESCE  = 4
) (
    input  logic                 sclk,
    input  logic                 srst_n,
    input  logic                 link_active_i,
    input  logic                 tlp_done_i,
    input  logic [SEQ_WIDTH-1:0] tlp_seq_i,
    input  logic                 tlp_crc_ok_i,
    output logic                 tlp_commit_o,
    output logic                 tlp_discard_o,
    output logic                 dllp_req_o,
    output logic                 dllp_type_o,
    output logic [SEQ_WIDTH-1:0] dllp_seq_o,
    input  logic                 dllp_gnt_i,
    output logic [SEQ_WIDTH-1:0] next_rcv_seq_o,
    output logic                 nak_scheduled_o
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int TMR_W = (ACK_TIMER_MAX > 1) ? $clog2(ACK_TIMER_MAX) : 1;
    localparam int CNT_W = $clog2(ACK_COALESCE + 1);

    localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(ACK_TIMER_MAX - 1);
    localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(ACK_COALESCE);
    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE   = SEQ_WIDTH'(1);
    // Half the sequence space: the duplicate window is 1..SEQ_HALF behind NRS.
    localparam logic [SEQ_WIDTH-1:0] SEQ_HALF  = SEQ_ONE << (SEQ_WIDTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK_REQ = 2'd1;
    localparam logic [1:0] ST_NAK_REQ = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]           state_q,     state_d;
    logic [SEQ_WIDTH-1:0] nrs_q,       nrs_d;
    logic                 nak_sched_q, nak_sched_d;
    logic                 ack_pend_q,  ack_pend_d;
    logic                 nak_pend_q,  nak_pend_d;
    logic [CNT_W-1:0]     unack_q,     unack_d;
    logic [TMR_W-1:0]     timer_q,     timer_d;
    logic                 req_q,       req_d;
    logic                 type_q,      type_d;
    logic [SEQ_WIDTH-1:0] dseq_q,      dseq_d;
    logic                 commit_q,    commit_d;
    logic                 discard_q,   discard_d;

    // -------------------------------------------------------------------------
    // TLP classification
    // -------------------------------------------------------------------------
    logic                 tlp_valid;
    logic                 tlp_in_seq;
    logic                 tlp_dup;
    logic [SEQ_WIDTH-1:0] seq_behind;

    assign tlp_valid  = link_active_i & tlp_done_i;
    assign seq_behind = nrs_q - tlp_seq_i;
    assign tlp_in_seq = (tlp_seq_i == nrs_q);
    assign tlp_dup    = (seq_behind != '0) && (seq_behind <= SEQ_HALF);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic new_nak;
    logic enter_ack;
    logic enter_nak;

    always_comb begin
        state_d     = state_q;
        nrs_d       = nrs_q;
        nak_sched_d = nak_sched_q;
        ack_pend_d  = ack_pend_q;
        nak_pend_d  = nak_pend_q;
        unack_d     = unack_q;
        timer_d     = timer_q;
        req_d       = req_q;
        type_d      = type_q;
        dseq_d      = dseq_q;
        commit_d    = 1'b0;
        discard_d   = 1'b0;
        new_nak     = 1'b0;
        enter_ack   = 1'b0;
        enter_nak   = 1'b0;

        // ---- received TLP handling ----
        if (tlp_valid) begin
            if (!tlp_crc_ok_i) begin
                discard_d = 1'b1;
                if (!nak_sched_q) begin
                    nak_sched_d = 1'b1;
                    new_nak     = 1'b1;
                end
            end else if (tlp_in_seq) begin
                commit_d    = 1'b1;
                nrs_d       = nrs_q + SEQ_ONE;
                nak_sched_d = 1'b0;
                // Saturate: once the coalesce limit is hit an Ack is already
                // pending, further counting adds nothing.
                if (unack_q != CNT_LIMIT) begin
                    unack_d = unack_q + CNT_W'(1);
                end
            end else if (tlp_dup) begin
                discard_d  = 1'b1;
                ack_pend_d = 1'b1;
            end else begin
                discard_d = 1'b1;
                if (!nak_sched_q) begin
                    nak_sched_d = 1'b1;
                    new_nak     = 1'b1;
                end
            end
        end

        // ---- ack timer ----
        // Counts from the cycle after the first un-acked commit, so it hits
        // TMR_LAST exactly ACK_TIMER_MAX-1 cycles after that commit. It holds
        // at TMR_LAST while an Ack waits behind a Nak.
        if (unack_q == '0) begin
            timer_d = '0;
        end else if (timer_q != TMR_LAST) begin
            timer_d = timer_q + TMR_W'(1);
        end

        if ((unack_d == CNT_LIMIT) || ((unack_d != '0) && (timer_d == TMR_LAST))) begin
            ack_pend_d = 1'b1;
        end

        // ---- DLLP request FSM ----
        case (state_q)
            ST_IDLE: begin
                if (nak_pend_q) begin
                    state_d   = ST_NAK_REQ;
                    enter_nak = 1'b1;
                end else if (ack_pend_q) begin
                    state_d   = ST_ACK_REQ;
                    enter_ack = 1'b1;
                end
            end
            ST_ACK_REQ, ST_NAK_REQ: begin
                if (dllp_gnt_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A Nak raised while another request is in flight stays pending; the
        // one being issued now is consumed first, so a fresh Nak in the same
        // cycle survives.
        nak_pend_d = (nak_pend_q & ~enter_nak) | new_nak;

        // The Ack carries post-update NRS-1, so it covers everything
        // committed so far including a commit in this very cycle.
        if (enter_ack) begin
            unack_d    = '0;
            timer_d    = '0;
            ack_pend_d = 1'b0;
        end

        if (enter_ack || enter_nak) begin
            req_d  = 1'b1;
            type_d = enter_nak;
            dseq_d = nrs_d - SEQ_ONE;
        end

        // Link down: everything back to reset values.
        if (!link_active_i) begin
            state_d     = ST_IDLE;
            nrs_d       = '0;
            nak_sched_d = 1'b0;
            ack_pend_d  = 1'b0;
            nak_pend_d  = 1'b0;
            unack_d     = '0;
            timer_d     = '0;
            req_d       = 1'b0;
            type_d      = 1'b0;
            dseq_d      = '0;
            commit_d    = 1'b0;
            discard_d   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q     <= ST_IDLE;
            nrs_q       <= '0;
            nak_sched_q <= 1'b0;
            ack_pend_q  <= 1'b0;
            nak_pend_q  <= 1'b0;
            unack_q     <= '0;
            timer_q     <= '0;
            req_q       <= 1'b0;
            type_q      <= 1'b0;
            dseq_q      <= '0;
            commit_q    <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nrs_q       <= nrs_d;
            nak_sched_q <= nak_sched_d;
            ack_pend_q  <= ack_pend_d;
            nak_pend_q  <= nak_pend_d;
            unack_q     <= unack_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            type_q      <= type_d;
            dseq_q      <= dseq_d;
            commit_q    <= commit_d;
            discard_q   <= discard_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tlp_commit_o    = commit_q;
    assign tlp_discard_o   = discard_q;
    assign dllp_req_o      = req_q;
    assign dllp_type_o     = type_q;
    assign dllp_seq_o      = dseq_q;
    assign next_rcv_seq_o  = nrs_q;
    assign nak_scheduled_o = nak_sched_q;

endmodule

// File: tb/tb_dll_ack_nak_gen.sv
// -----------------------------------------------------------------------------
// tb_dll_ack_nak_gen
//
// Self-checking bench for dll_ack_nak_gen (defaults: 12-bit seq, timer 64,
// coalesce 4). A behavioural model tracks the receiver in plain integers and
// is compared with the DUT after every clock; directed tables and sequences
// add hand-computed expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_dll_ack_nak_gen;

    localparam int SW    = 12;
    localparam int MOD   = 4096;
    localparam int TMAX  = 64;
    localparam int COAL  = 4;

    logic          sclk = 1'b0;
    logic          srst_n;
    logic          link_active_i;
    logic          tlp_done_i;
    logic [SW-1:0] tlp_seq_i;
    logic          tlp_crc_ok_i;
    logic          tlp_commit_o;
    logic          tlp_discard_o;
    logic          dllp_req_o;
    logic          dllp_type_o;
    logic [SW-1:0] dllp_seq_o;
    logic          dllp_gnt_i;
    logic [SW-1:0] next_rcv_seq_o;
    logic          nak_scheduled_o;

    dll_ack_nak_gen #(
        .SEQ_WIDTH     (SW),
        .ACK_TIMER_MAX (TMAX),
        .ACK_COALESCE  (COAL)
    ) dut (
        .sclk            (sclk),
        .srst_n          (srst_n),
        .link_active_i   (link_active_i),
        .tlp_done_i      (tlp_done_i),
        .tlp_seq_i       (tlp_seq_i),
        .tlp_crc_ok_i    (tlp_crc_ok_i),
        .tlp_commit_o    (tlp_commit_o),
        .tlp_discard_o   (tlp_discard_o),
        .dllp_req_o      (dllp_req_o),
        .dllp_type_o     (dllp_type_o),
        .dllp_seq_o      (dllp_seq_o),
        .dllp_gnt_i      (dllp_gnt_i),
        .next_rcv_seq_o  (next_rcv_seq_o),
        .nak_scheduled_o (nak_scheduled_o)
    );

    always #5 sclk = ~sclk;

    int tests = 0;
    int fails = 0;

    // ---------------- behavioural model ----------------
    int m_nrs;      // next expected sequence number
    bit m_naks;     // Nak episode open
    int m_cnt;      // committed but not yet acknowledged
    int m_age;      // cycles since the oldest un-acked commit
    bit m_ackw;     // an Ack is wanted
    bit m_nakw;     // a Nak is wanted
    bit m_req;      // DLLP request visible
    bit m_type;
    int m_dseq;
    bit m_commit;
    bit m_discard;

    task automatic model_reset();
        m_nrs = 0; m_naks = 0; m_cnt = 0; m_age = 0; m_ackw = 0; m_nakw = 0;
        m_req = 0; m_type = 0; m_dseq = 0; m_commit = 0; m_discard = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input bit done, input int seq, input bit crc,
                              input bit gnt, input bit link);
        bit enter_ack, enter_nak, nak_new;
        int cnt_old, behind;
        enter_ack = 0; enter_nak = 0; nak_new = 0;
        if (!link) begin
            model_reset();
            return;
        end
        cnt_old = m_cnt;
        if (m_req) begin
            if (gnt) m_req = 0;
        end else if (m_nakw) begin
            enter_nak = 1;
        end else if (m_ackw) begin
            enter_ack = 1;
        end
        m_commit = 0; m_discard = 0;
        if (done) begin
            behind = (m_nrs - seq + MOD) % MOD;
            if (!crc) begin
                m_discard = 1;
                if (!m_naks) begin m_naks = 1; nak_new = 1; end
            end else if (seq == m_nrs) begin
                m_commit = 1;
                m_nrs = (m_nrs + 1) % MOD;
                m_naks = 0;
                m_cnt++;
            end else if (behind >= 1 && behind <= MOD / 2) begin
                m_discard = 1;
                m_ackw = 1;
            end else begin
                m_discard = 1;
                if (!m_naks) begin m_naks = 1; nak_new = 1; end
            end
        end
        m_age = (cnt_old > 0) ? ((m_age + 1 > TMAX - 1) ? TMAX - 1 : m_age + 1) : 0;
        if (m_cnt >= COAL || (m_cnt > 0 && m_age >= TMAX - 1)) m_ackw = 1;
        if (enter_nak) m_nakw = 0;
        if (nak_new)   m_nakw = 1;
        if (enter_ack) begin m_cnt = 0; m_age = 0; m_ackw = 0; end
        if (enter_ack || enter_nak) begin
            m_req  = 1;
            m_type = enter_nak;
            m_dseq = (m_nrs + MOD - 1) % MOD;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model.commit",  int'(tlp_commit_o),    int'(m_commit));
        chk("model.discard", int'(tlp_discard_o),   int'(m_discard));
        chk("model.req",     int'(dllp_req_o),      int'(m_req));
        chk("model.nrs",     int'(next_rcv_seq_o),  m_nrs);
        chk("model.naks",    int'(nak_scheduled_o), int'(m_naks));
        if (m_req) begin
            chk("model.type", int'(dllp_type_o), int'(m_type));
            chk("model.dseq", int'(dllp_seq_o),  m_dseq);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), clock it,
    // then compare DUT against model 1 ns after the edge.
    task automatic cycle(input bit done, input int seq, input bit crc, input bit gnt);
        tlp_done_i   = done;
        tlp_seq_i    = SW'(seq);
        tlp_crc_ok_i = crc;
        dllp_gnt_i   = gnt;
        model_step(done, seq, crc, gnt, link_active_i);
        @(posedge sclk);
        #1;
        compare_model();
        tlp_done_i = 1'b0;
        dllp_gnt_i = 1'b0;
    endtask

    task automatic link_clear();
        link_active_i = 1'b0;
        cycle(0, 0, 1, 0);
        link_active_i = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit done; int seq; bit crc; bit gnt;
        bit commit; bit discard; bit req; bit typ; int dseq; int nrs; bit naks;
    } vec_t;

    vec_t vecs [16];

    initial begin
        bit seen;
        int reqs_seen;
        int r;
        int seq;

        // Bad CRC / Nak episode, then coalesce Ack with coincident commit,
        // duplicate Ack, grant coincident with an ahead TLP.
        vecs[0]  = '{1, 0, 0, 0,  0, 1, 0, 0, 0,    0, 1};
        vecs[1]  = '{0, 0, 1, 0,  0, 0, 1, 1, 4095, 0, 1};
        vecs[2]  = '{1, 0, 0, 0,  0, 1, 1, 1, 4095, 0, 1};
        vecs[3]  = '{0, 0, 1, 1,  0, 0, 0, 0, 0,    0, 1};
        vecs[4]  = '{0, 0, 1, 0,  0, 0, 0, 0, 0,    0, 1};
        vecs[5]  = '{1, 0, 1, 0,  1, 0, 0, 0, 0,    1, 0};
        vecs[6]  = '{1, 1, 1, 0,  1, 0, 0, 0, 0,    2, 0};
        vecs[7]  = '{1, 2, 1, 0,  1, 0, 0, 0, 0,    3, 0};
        vecs[8]  = '{1, 3, 1, 0,  1, 0, 0, 0, 0,    4, 0};
        vecs[9]  = '{1, 4, 1, 0,  1, 0, 1, 0, 4,    5, 0};
        vecs[10] = '{0, 0, 1, 1,  0, 0, 0, 0, 0,    5, 0};
        vecs[11] = '{1, 3, 1, 0,  0, 1, 0, 0, 0,    5, 0};
        vecs[12] = '{0, 0, 1, 0,  0, 0, 1, 0, 4,    5, 0};
        vecs[13] = '{1, 9, 1, 1,  0, 1, 0, 0, 0,    5, 1};
        vecs[14] = '{0, 0, 1, 0,  0, 0, 1, 1, 4,    5, 1};
        vecs[15] = '{0, 0, 1, 1,  0, 0, 0, 0, 0,    5, 1};

        // ---------------- reset ----------------
        srst_n        = 1'b0;
        link_active_i = 1'b1;
        tlp_done_i    = 1'b0;
        tlp_seq_i     = '0;
        tlp_crc_ok_i  = 1'b1;
        dllp_gnt_i    = 1'b0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        chk("reset.req",     int'(dllp_req_o),      0);
        chk("reset.type",    int'(dllp_type_o),     0);
        chk("reset.dseq",    int'(dllp_seq_o),      0);
        chk("reset.commit",  int'(tlp_commit_o),    0);
        chk("reset.discard", int'(tlp_discard_o),   0);
        chk("reset.nrs",     int'(next_rcv_seq_o),  0);
        chk("reset.naks",    int'(nak_scheduled_o), 0);
        srst_n = 1'b1;

        // ---------------- four back-to-back commits, gnt held 1 ----------------
        for (int s = 0; s < 4; s++) begin
            cycle(1, s, 1, 1);
            chk("b2b.commit", int'(tlp_commit_o), 1);
        end
        chk("b2b.nrs", int'(next_rcv_seq_o), 4);
        chk("b2b.req_before", int'(dllp_req_o), 0);
        cycle(0, 0, 1, 1);
        chk("b2b.req", int'(dllp_req_o), 1);
        chk("b2b.type", int'(dllp_type_o), 0);
        chk("b2b.dseq", int'(dllp_seq_o), 3);
        cycle(0, 0, 1, 1);
        chk("b2b.req_drop", int'(dllp_req_o), 0);
        $display("[TB] b2b commits: nrs=%0d", next_rcv_seq_o);

        // ---------------- ack timer, grant withheld ----------------
        link_clear();
        cycle(1, 0, 1, 0);
        chk("timer.commit", int'(tlp_commit_o), 1);
        for (int i = 1; i <= 100; i++) begin
            cycle(0, 0, 1, 0);
            if (i == TMAX - 1) chk("timer.req_early", int'(dllp_req_o), 0);
            if (i == TMAX) begin
                chk("timer.req_on_time", int'(dllp_req_o), 1);
                chk("timer.dseq", int'(dllp_seq_o), 0);
            end
        end
        chk("timer.req_held", int'(dllp_req_o), 1);
        chk("timer.type_held", int'(dllp_type_o), 0);
        chk("timer.dseq_held", int'(dllp_seq_o), 0);
        cycle(0, 0, 1, 1);
        chk("timer.req_drop", int'(dllp_req_o), 0);
        $display("[TB] timer ack: released after grant");

        // ---------------- table-driven sequence ----------------
        link_clear();
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].done, vecs[i].seq, vecs[i].crc, vecs[i].gnt);
            chk($sformatf("vec%0d.commit", i),  int'(tlp_commit_o),    int'(vecs[i].commit));
            chk($sformatf("vec%0d.discard", i), int'(tlp_discard_o),   int'(vecs[i].discard));
            chk($sformatf("vec%0d.req", i),     int'(dllp_req_o),      int'(vecs[i].req));
            chk($sformatf("vec%0d.nrs", i),     int'(next_rcv_seq_o),  vecs[i].nrs);
            chk($sformatf("vec%0d.naks", i),    int'(nak_scheduled_o), int'(vecs[i].naks));
            if (vecs[i].req) begin
                chk($sformatf("vec%0d.type", i), int'(dllp_type_o), int'(vecs[i].typ));
                chk($sformatf("vec%0d.dseq", i), int'(dllp_seq_o),  vecs[i].dseq);
            end
            $display("[TB] vec%0d done=%0d seq=%0d crc=%0d gnt=%0d -> commit=%0d discard=%0d req=%0d type=%0d dseq=%0d nrs=%0d",
                     i, vecs[i].done, vecs[i].seq, vecs[i].crc, vecs[i].gnt, tlp_commit_o,
                     tlp_discard_o, dllp_req_o, dllp_type_o, dllp_seq_o, next_rcv_seq_o);
        end

        // ---------------- sequence-number wrap ----------------
        link_clear();
        for (int s = 0; s < MOD - 1; s++) cycle(1, s, 1, 1);
        for (int i = 0; i < 80; i++) cycle(0, 0, 1, 1);
        chk("wrap.nrs_pre", int'(next_rcv_seq_o), 4095);
        chk("wrap.idle_pre", int'(dllp_req_o), 0);
        cycle(1, 4095, 1, 0);
        chk("wrap.commit", int'(tlp_commit_o), 1);
        chk("wrap.nrs", int'(next_rcv_seq_o), 0);
        seen = 0;
        for (int i = 0; i < 70 && !seen; i++) begin
            cycle(0, 0, 1, 0);
            if (dllp_req_o) seen = 1;
        end
        chk("wrap.ack_seen", int'(seen), 1);
        chk("wrap.type", int'(dllp_type_o), 0);
        chk("wrap.dseq", int'(dllp_seq_o), 4095);
        cycle(0, 0, 1, 1);
        $display("[TB] wrap: ack seq observed %0d", dllp_seq_o);

        // ---------------- reset in the middle of an Ack request ----------------
        link_clear();
        for (int s = 0; s < 4; s++) cycle(1, s, 1, 0);
        cycle(0, 0, 1, 0);
        chk("rstreq.req_before", int'(dllp_req_o), 1);
        #2;
        srst_n = 1'b0;
        #1;
        chk("rstreq.req_async", int'(dllp_req_o), 0);
        chk("rstreq.nrs_async", int'(next_rcv_seq_o), 0);
        model_reset();
        #1;
        srst_n = 1'b1;
        reqs_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 1);
            if (dllp_req_o) reqs_seen++;
        end
        chk("rstreq.no_dllp_after", reqs_seen, 0);
        $display("[TB] reset mid-request: req after release count=%0d", reqs_seen);

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1, 2, 3, 4: seq = m_nrs;
                5:  seq = (m_nrs - 1 + MOD) % MOD;
                6:  seq = (m_nrs - int'($urandom_range(1, 20)) + MOD) % MOD;
                7:  seq = (m_nrs - 2048 + MOD) % MOD;
                8:  seq = (m_nrs + 2047) % MOD;
                9:  seq = (m_nrs + int'($urandom_range(1, 20))) % MOD;
                default: seq = int'($urandom_range(0, MOD - 1));
            endcase
            link_active_i = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 1) == 1, seq, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2) != 0);
            link_active_i = 1'b1;
        end
        $display("[TB] random phase complete, nrs=%0d", next_rcv_seq_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dll_ack_nak_gen.md
DLL_ACK_NAK_GEN -- requirements
Module: dll_ack_nak_gen

Interface
REQ-001 SHALL have parameter SEQ_WIDTH, default 12, TLP sequence-number width (mod 4096 arithmetic).
REQ-002 SHALL have parameter ACK_TIMER_MAX, default 64, cycles from first un-acked commit to forced Ack.
REQ-003 SHALL have parameter ACK_COALESCE, default 4, un-acked committed TLPs that trigger an immediate Ack.
REQ-004 SHALL use one clock and an asynchronous active-low reset, named sclk and srst_n.
REQ-005 sclk  input  1  system clock, all state on rising edge.
REQ-006 srst_n  input  1  asynchronous active-low reset.
REQ-007 link_active_i  input  1  link up; low synchronously clears all state to reset values.
REQ-008 tlp_done_i  input  1  one-cycle pulse at the end of a received TLP.
REQ-009 tlp_seq_i  input  SEQ_WIDTH  sequence number of that TLP, valid with tlp_done_i.
REQ-010 tlp_crc_ok_i  input  1  LCRC check passed, valid with tlp_done_i.
REQ-011 tlp_commit_o  output  1  one-cycle pulse: TLP accepted, forward to TL.
REQ-012 tlp_discard_o  output  1  one-cycle pulse: TLP dropped.
REQ-013 dllp_req_o  output  1  Ack/Nak DLLP request to the DLL transmit path.
REQ-014 dllp_type_o  output  1  0 = Ack, 1 = Nak.
REQ-015 dllp_seq_o  output  SEQ_WIDTH  AckNak_Seq_Num carried by the DLLP.
REQ-016 dllp_gnt_i  input  1  transmit path accepted the DLLP this cycle.
REQ-017 next_rcv_seq_o  output  SEQ_WIDTH  current NEXT_RCV_SEQ (NRS).
REQ-018 nak_scheduled_o  output  1  Nak outstanding; set until an in-sequence good TLP arrives.

Function
REQ-019 tlp_commit_o/tlp_discard_o SHALL be registered, asserted the cycle after tlp_done_i; exactly one per tlp_done_i.
REQ-020 On tlp_done_i with tlp_crc_ok_i=0: discard; if nak_scheduled=0, set it and schedule a Nak.
REQ-021 Good and tlp_seq_i==NRS: commit; NRS <= NRS+1 mod 2^SEQ_WIDTH (4095 wraps to 0); clear nak_scheduled; un-acked count +1.
REQ-022 Good and (NRS - tlp_seq_i) mod 4096 in 1..2048 (duplicate): discard; schedule an Ack immediately, bypassing the timer.
REQ-023 Good, any other seq (ahead/lost TLP): discard; schedule a Nak if nak_scheduled=0, else nothing.
REQ-024 Ack timer: 0 while un-acked count==0; increments each cycle otherwise; at ACK_TIMER_MAX-1, or when un-acked count reaches ACK_COALESCE, schedule an Ack.
REQ-025 FSM states IDLE, ACK_REQ, NAK_REQ; IDLE->NAK_REQ if a Nak is pending, else IDLE->ACK_REQ if an Ack is pending; Nak has priority.
REQ-026 On entering ACK_REQ/NAK_REQ: dllp_seq_o <= NRS-1 mod 4096 (post-update NRS if a commit occurs the same cycle); dllp_req_o=1; type per state.
REQ-027 dllp_req_o, dllp_type_o, dllp_seq_o SHALL stay stable until the cycle dllp_gnt_i=1; next cycle returns to IDLE, dllp_req_o=0.
REQ-028 Entering ACK_REQ SHALL clear the un-acked count, the ack timer and the pending-Ack flag; commits during ACK_REQ re-arm them.
REQ-029 A Nak scheduled while in ACK_REQ SHALL be held pending and issued after the Ack grant (IDLE then NAK_REQ); it is never dropped.
REQ-030 A Nak is sent at most once per nak_scheduled set; nak_scheduled SHALL stay 1 after the grant until REQ-021 clears it.
REQ-031 tlp_done_i coincident with dllp_gnt_i: the grant completes the current DLLP; the new event is evaluated the same cycle and issued from IDLE next cycle.
REQ-032 With link_active_i=0: tlp_done_i ignored, no commit/discard, FSM forced to IDLE, outputs at reset values.
REQ-033 dllp_gnt_i with dllp_req_o=0 SHALL be ignored.

Reset
REQ-034 While srst_n=0, asynchronously: NRS=0, nak_scheduled_o=0, dllp_req_o=0, dllp_type_o=0, dllp_seq_o=0, tlp_commit_o=0, tlp_discard_o=0, timer/count=0, FSM=IDLE.
REQ-035 Reset asserted mid-request drops dllp_req_o in the same cycle; no grant is needed and no pending Ack/Nak survives.

Verification
REQ-036 Good seq 0,1,2,3 back-to-back, gnt=1 -> four commits, NRS=4, Ack dllp_seq_o=3 requested the cycle after the 4th commit; req drops after gnt.
REQ-037 One good seq 0, gnt held 0 for 100 cycles -> Ack seq 0 requested ACK_TIMER_MAX (64) cycles after commit, held stable until gnt.
REQ-038 Bad CRC at NRS=0 -> discard, Nak seq 4095, nak_scheduled=1; second bad -> no second Nak; good seq 0 -> commit, nak_scheduled=0.
REQ-039 NRS=5, good seq 3 -> discard, immediate Ack seq 4; good seq 9 -> discard, Nak seq 4.
REQ-040 NRS=4095, good seq 4095 -> commit, NRS=0; subsequent Ack carries seq 4095.
REQ-041 srst_n low while dllp_req_o=1 in ACK_REQ -> dllp_req_o=0 immediately, NRS=0; after release no DLLP without new TLPs.
